// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode of the incoming word captured into a
// registered output entry backed by a one-entry skid buffer (valid/ready both sides).

package decode_stage_pkg;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned ALUOP_W = 5;
    localparam int unsigned CLASS_W = 3;
    localparam int unsigned BMASK_W = 6;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 5'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB    = 5'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL    = 5'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT    = 5'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU   = 5'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR    = 5'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL    = 5'd6;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA    = 5'd7;
    localparam logic [ALUOP_W-1:0] ALUOP_OR     = 5'd8;
    localparam logic [ALUOP_W-1:0] ALUOP_AND    = 5'd9;
    localparam logic [ALUOP_W-1:0] ALUOP_MUL    = 5'd10;
    localparam logic [ALUOP_W-1:0] ALUOP_MULH   = 5'd11;
    localparam logic [ALUOP_W-1:0] ALUOP_MULHSU = 5'd12;
    localparam logic [ALUOP_W-1:0] ALUOP_MULHU  = 5'd13;
    localparam logic [ALUOP_W-1:0] ALUOP_DIV    = 5'd14;
    localparam logic [ALUOP_W-1:0] ALUOP_DIVU   = 5'd15;
    localparam logic [ALUOP_W-1:0] ALUOP_REM    = 5'd16;
    localparam logic [ALUOP_W-1:0] ALUOP_REMU   = 5'd17;

    localparam logic [CLASS_W-1:0] CLASS_ALU    = 3'd0;
    localparam logic [CLASS_W-1:0] CLASS_LOAD   = 3'd1;
    localparam logic [CLASS_W-1:0] CLASS_STORE  = 3'd2;
    localparam logic [CLASS_W-1:0] CLASS_BRANCH = 3'd3;
    localparam logic [CLASS_W-1:0] CLASS_JUMP   = 3'd4;
    localparam logic [CLASS_W-1:0] CLASS_LUI    = 3'd5;
    localparam logic [CLASS_W-1:0] CLASS_SYS    = 3'd6;
    localparam logic [CLASS_W-1:0] CLASS_TRAP   = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic [XLEN-1:0]    imm;
        logic [F3_W-1:0]    funct3;
        logic [ALUOP_W-1:0] aluop;
        logic               s1_pc;
        logic               s2_imm;
        logic [CLASS_W-1:0] cls;
        logic [BMASK_W-1:0] branchmask;
        logic               write_reg;
        logic               illegal;
    } dec_t;
endpackage

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter bit          HAS_MUL  = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               I_clk,
    input  logic               I_reset,
    input  logic               I_flush,
    input  logic               I_valid,
    output logic               O_ready,
    input  logic [XLEN-1:0]    I_instr,
    input  logic [XLEN-1:0]    I_pc,
    output logic               O_valid,
    input  logic               I_ready,
    output logic [XLEN-1:0]    O_pc,
    output logic [REG_W-1:0]   O_rs1,
    output logic [REG_W-1:0]   O_rs2,
    output logic [REG_W-1:0]   O_rd,
    output logic [XLEN-1:0]    O_imm,
    output logic [F3_W-1:0]    O_funct3,
    output logic [ALUOP_W-1:0] O_aluop,
    output logic               O_s1_pc,
    output logic               O_s2_imm,
    output logic [CLASS_W-1:0] O_class,
    output logic [BMASK_W-1:0] O_branchmask,
    output logic               O_write_reg,
    output logic               O_illegal
);

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    logic [6:0]         opcode;
    logic [F3_W-1:0]    f3;
    logic [6:0]         f7;
    logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [ALUOP_W-1:0] base_op, mul_op;
    logic [BMASK_W-1:0] bmask;
    dec_t               dec_c;

    assign opcode = I_instr[6:0];
    assign f3     = I_instr[14:12];
    assign f7     = I_instr[31:25];
    assign imm_i  = {{20{I_instr[31]}}, I_instr[31:20]};
    assign imm_s  = {{20{I_instr[31]}}, I_instr[31:25], I_instr[11:7]};
    assign imm_b  = {{19{I_instr[31]}}, I_instr[31], I_instr[7], I_instr[30:25], I_instr[11:8], 1'b0};
    assign imm_u  = {I_instr[31:12], 12'h000};
    assign imm_j  = {{11{I_instr[31]}}, I_instr[31], I_instr[19:12], I_instr[20], I_instr[30:21], 1'b0};

    // Per-funct3 operation tables; bit 30 selects the arithmetic right shift.
    always_comb begin
        base_op = ALUOP_AND;
        mul_op  = ALUOP_REMU;
        bmask   = '0;
        case (f3)
            3'b000:  base_op = ALUOP_ADD;
            3'b001:  base_op = ALUOP_SLL;
            3'b010:  base_op = ALUOP_SLT;
            3'b011:  base_op = ALUOP_SLTU;
            3'b100:  base_op = ALUOP_XOR;
            3'b101:  base_op = I_instr[30] ? ALUOP_SRA : ALUOP_SRL;
            3'b110:  base_op = ALUOP_OR;
            default: base_op = ALUOP_AND;
        endcase
        case (f3)
            3'b000:  mul_op = ALUOP_MUL;
            3'b001:  mul_op = ALUOP_MULH;
            3'b010:  mul_op = ALUOP_MULHSU;
            3'b011:  mul_op = ALUOP_MULHU;
            3'b100:  mul_op = ALUOP_DIV;
            3'b101:  mul_op = ALUOP_DIVU;
            3'b110:  mul_op = ALUOP_REM;
            default: mul_op = ALUOP_REMU;
        endcase
        case (f3)
            3'b000:  bmask = 6'b000001;
            3'b001:  bmask = 6'b000010;
            3'b100:  bmask = 6'b000100;
            3'b101:  bmask = 6'b001000;
            3'b110:  bmask = 6'b010000;
            3'b111:  bmask = 6'b100000;
            default: bmask = '0;
        endcase
    end

    // Full decode with illegal-encoding detection.
    always_comb begin
        dec_c        = '0;
        dec_c.pc     = I_pc;
        dec_c.rs1    = I_instr[19:15];
        dec_c.rs2    = I_instr[24:20];
        dec_c.rd     = I_instr[11:7];
        dec_c.funct3 = f3;
        dec_c.aluop  = ALUOP_ADD;
        dec_c.cls    = CLASS_ALU;
        case (opcode)
            OPC_OP: begin
                case (f7)
                    7'b0000000: dec_c.aluop = base_op;
                    7'b0100000: begin
                        if (f3 == 3'b000)      dec_c.aluop = ALUOP_SUB;
                        else if (f3 == 3'b101) dec_c.aluop = ALUOP_SRA;
                        else                   dec_c.illegal = 1'b1;
                    end
                    7'b0000001: begin
                        dec_c.aluop   = mul_op;
                        dec_c.illegal = !HAS_MUL;
                    end
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_c.imm    = imm_i;
                dec_c.s2_imm = 1'b1;
                dec_c.aluop  = base_op;
                if (f3 == 3'b001 && f7 != 7'b0000000)
                    dec_c.illegal = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                    dec_c.illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec_c.cls     = CLASS_LOAD;
                dec_c.imm     = imm_i;
                dec_c.s2_imm  = 1'b1;
                dec_c.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec_c.cls     = CLASS_STORE;
                dec_c.imm     = imm_s;
                dec_c.s2_imm  = 1'b1;
                dec_c.illegal = (f3 >= 3'b011);
            end
            OPC_BRANCH: begin
                dec_c.cls        = CLASS_BRANCH;
                dec_c.imm        = imm_b;
                dec_c.branchmask = bmask;
                dec_c.illegal    = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: begin
                dec_c.cls    = CLASS_JUMP;
                dec_c.imm    = imm_j;
                dec_c.s1_pc  = 1'b1;
                dec_c.s2_imm = 1'b1;
            end
            OPC_JALR: begin
                dec_c.cls     = CLASS_JUMP;
                dec_c.imm     = imm_i;
                dec_c.s2_imm  = 1'b1;
                dec_c.illegal = (f3 != 3'b000);
            end
            OPC_LUI: begin
                dec_c.cls    = CLASS_LUI;
                dec_c.imm    = imm_u;
                dec_c.s2_imm = 1'b1;
            end
            OPC_AUIPC: begin
                dec_c.imm    = imm_u;
                dec_c.s1_pc  = 1'b1;
                dec_c.s2_imm = 1'b1;
            end
            OPC_MISCMEM, OPC_SYSTEM: begin
                dec_c.cls = CLASS_SYS;
                dec_c.imm = imm_i;
            end
            default: dec_c.illegal = 1'b1;
        endcase
        if (dec_c.illegal) begin
            dec_c.cls        = CLASS_TRAP;
            dec_c.branchmask = '0;
        end
        dec_c.write_reg = !dec_c.illegal && (dec_c.rd != '0) &&
                          (dec_c.cls inside {CLASS_ALU, CLASS_LOAD, CLASS_JUMP, CLASS_LUI});
    end

    logic accept, drain;
    logic main_v_q, main_v_d, skid_v_q, skid_v_d, ready_q, ready_d;
    dec_t main_q, main_d, skid_q, skid_d;

    assign accept = I_valid & ready_q;
    assign drain  = main_v_q & I_ready;

    // Main/skid steering; skid always refills main before any new word.
    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (I_flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || drain) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept) begin
                main_d   = dec_c;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_d   = dec_c;
            skid_v_d = 1'b1;
        end
        ready_d = !skid_v_d;
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            ready_q     <= 1'b1;
            main_q      <= '0;
            main_q.pc   <= RESET_PC;
            skid_q      <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            ready_q     <= ready_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
        end
    end

    assign O_ready      = ready_q;
    assign O_valid      = main_v_q;
    assign O_pc         = main_q.pc;
    assign O_rs1        = main_q.rs1;
    assign O_rs2        = main_q.rs2;
    assign O_rd         = main_q.rd;
    assign O_imm        = main_q.imm;
    assign O_funct3     = main_q.funct3;
    assign O_aluop      = main_q.aluop;
    assign O_s1_pc      = main_q.s1_pc;
    assign O_s2_imm     = main_q.s2_imm;
    assign O_class      = main_q.cls;
    assign O_branchmask = main_q.branchmask;
    assign O_write_reg  = main_q.write_reg;
    assign O_illegal    = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed decodes, backpressure, flush, async reset
// and a randomized stream checked against a queue-based model with an arithmetic decoder.

module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [4:0]  aluop;
        logic        s1pc, s2imm;
        logic [2:0]  cls;
        logic [5:0]  bmask;
        logic        wr, ill;
    } exp_t;

    logic        I_clk, I_reset, I_flush, I_valid, I_ready;
    logic [31:0] I_instr, I_pc;
    logic        O_ready, O_valid, O_s1_pc, O_s2_imm, O_write_reg, O_illegal;
    logic [31:0] O_pc, O_imm;
    logic [4:0]  O_rs1, O_rs2, O_rd, O_aluop;
    logic [2:0]  O_funct3, O_class;
    logic [5:0]  O_branchmask;
    logic        n_ready, n_valid, n_s1_pc, n_s2_imm, n_write_reg, n_illegal;
    logic [31:0] n_pc, n_imm;
    logic [4:0]  n_rs1, n_rs2, n_rd, n_aluop;
    logic [2:0]  n_funct3, n_class;
    logic [5:0]  n_branchmask;

    int checks = 0;
    int errors = 0;
    logic [63:0] mq[$];   // model: {pc, instr} of buffered instructions, oldest first

    decode_stage #(.HAS_MUL(1'b1), .RESET_PC(RST_PC)) u_dut (
        .I_clk(I_clk), .I_reset(I_reset), .I_flush(I_flush), .I_valid(I_valid),
        .O_ready(O_ready), .I_instr(I_instr), .I_pc(I_pc), .O_valid(O_valid),
        .I_ready(I_ready), .O_pc(O_pc), .O_rs1(O_rs1), .O_rs2(O_rs2), .O_rd(O_rd),
        .O_imm(O_imm), .O_funct3(O_funct3), .O_aluop(O_aluop), .O_s1_pc(O_s1_pc),
        .O_s2_imm(O_s2_imm), .O_class(O_class), .O_branchmask(O_branchmask),
        .O_write_reg(O_write_reg), .O_illegal(O_illegal));

    decode_stage #(.HAS_MUL(1'b0), .RESET_PC(RST_PC)) u_dut_nm (
        .I_clk(I_clk), .I_reset(I_reset), .I_flush(I_flush), .I_valid(I_valid),
        .O_ready(n_ready), .I_instr(I_instr), .I_pc(I_pc), .O_valid(n_valid),
        .I_ready(I_ready), .O_pc(n_pc), .O_rs1(n_rs1), .O_rs2(n_rs2), .O_rd(n_rd),
        .O_imm(n_imm), .O_funct3(n_funct3), .O_aluop(n_aluop), .O_s1_pc(n_s1_pc),
        .O_s2_imm(n_s2_imm), .O_class(n_class), .O_branchmask(n_branchmask),
        .O_write_reg(n_write_reg), .O_illegal(n_illegal));

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference decoder: immediates from weighted bit fields, ops from lookup tables.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input bit has_mul);
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        int ii, is_, ib, ij;
        logic [4:0] base_tbl [8];
        logic [4:0] mul_tbl [8];
        int bidx [8];
        base_tbl = '{ALUOP_ADD, ALUOP_SLL, ALUOP_SLT, ALUOP_SLTU,
                     ALUOP_XOR, ALUOP_SRL, ALUOP_OR, ALUOP_AND};
        mul_tbl  = '{ALUOP_MUL, ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU,
                     ALUOP_DIV, ALUOP_DIVU, ALUOP_REM, ALUOP_REMU};
        bidx     = '{0, 1, -1, -1, 2, 3, 4, 5};
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        ii  = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
        is_ = int'(ins[11:7]) + 32 * int'(ins[30:25]) - (ins[31] ? 2048 : 0);
        ib  = 2 * int'(ins[11:8]) + 32 * int'(ins[30:25]) + (ins[7] ? 2048 : 0)
              - (ins[31] ? 4096 : 0);
        ij  = 2 * int'(ins[30:21]) + (ins[20] ? 2048 : 0) + 4096 * int'(ins[19:12])
              - (ins[31] ? (1 << 20) : 0);
        e = '0;
        e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
        e.aluop = ALUOP_ADD;
        case (op)
            7'b0110011: begin
                if (f7 == 7'h00)                      e.aluop = base_tbl[f3];
                else if (f7 == 7'h20 && f3 == 3'd0)  e.aluop = ALUOP_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5)  e.aluop = ALUOP_SRA;
                else if (f7 == 7'h01 && has_mul)     e.aluop = mul_tbl[f3];
                else                                  e.ill = 1'b1;
            end
            7'b0010011: begin
                e.imm = 32'(ii); e.s2imm = 1'b1; e.aluop = base_tbl[f3];
                if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20)      e.aluop = ALUOP_SRA;
                    else if (f7 != 7'h00) e.ill = 1'b1;
                end
            end
            7'b0000011: begin
                e.cls = 3'd1; e.imm = 32'(ii); e.s2imm = 1'b1;
                e.ill = (f3 inside {3'd3, 3'd6, 3'd7});
            end
            7'b0100011: begin
                e.cls = 3'd2; e.imm = 32'(is_); e.s2imm = 1'b1; e.ill = (f3 > 3'd2);
            end
            7'b1100011: begin
                e.cls = 3'd3; e.imm = 32'(ib);
                if (bidx[f3] < 0) e.ill = 1'b1;
                else              e.bmask = 6'(1 << bidx[f3]);
            end
            7'b1101111: begin e.cls = 3'd4; e.imm = 32'(ij); e.s1pc = 1'b1; e.s2imm = 1'b1; end
            7'b1100111: begin e.cls = 3'd4; e.imm = 32'(ii); e.s2imm = 1'b1; e.ill = (f3 != 3'd0); end
            7'b0110111: begin e.cls = 3'd5; e.imm = ins - 32'(ins[11:0]); e.s2imm = 1'b1; end
            7'b0010111: begin e.imm = ins - 32'(ins[11:0]); e.s1pc = 1'b1; e.s2imm = 1'b1; end
            7'b0001111, 7'b1110011: begin e.cls = 3'd6; e.imm = 32'(ii); end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin e.cls = 3'd7; e.bmask = '0; end
        e.wr = !e.ill && e.rd != 5'd0 && (e.cls inside {3'd0, 3'd1, 3'd4, 3'd5});
        return e;
    endfunction

    // imm/aluop/operand selects are unspecified for illegal words and not compared.
    function automatic bit dut_matches(input exp_t e);
        bit ok;
        ok = (O_pc === e.pc) && (O_rs1 === e.rs1) && (O_rs2 === e.rs2) && (O_rd === e.rd) &&
             (O_funct3 === e.f3) && (O_class === e.cls) && (O_branchmask === e.bmask) &&
             (O_write_reg === e.wr) && (O_illegal === e.ill);
        if (!e.ill)
            ok = ok && (O_imm === e.imm) && (O_aluop === e.aluop) &&
                 (O_s1_pc === e.s1pc) && (O_s2_imm === e.s2imm);
        return ok;
    endfunction

    function automatic logic [99:0] obs();
        return {O_pc, O_rs1, O_rs2, O_rd, O_imm, O_funct3, O_aluop, O_s1_pc, O_s2_imm,
                O_class, O_branchmask, O_write_reg, O_illegal};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] ops [11];
        int k;
        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110011,
                7'b0010011, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};
        w = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) w[6:0] = ops[k];
        else if (k == 11) w[6:0] = 7'b0110011;
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    // One clock: advance the model from the inputs held across the edge.
    task automatic tick();
        bit acc, drn;
        acc = I_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && I_ready;
        @(posedge I_clk);
        if (I_flush) mq.delete();
        else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back({I_pc, I_instr});
        end
        #1;
    endtask

    task automatic test_reset();
        I_reset = 1'b1; I_flush = 1'b0; I_valid = 1'b0; I_ready = 1'b1;
        I_instr = '0; I_pc = '0;
        repeat (2) @(posedge I_clk);
        #1;
        I_reset = 1'b0;
        #1;
        checks++;
        if ({O_valid, O_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_handshake: got valid/ready=%b%b want 01", O_valid, O_ready);
        end
        checks++;
        if (O_pc !== RST_PC) begin
            errors++; $display("FAIL reset_pc: got %h want %h", O_pc, RST_PC);
        end
        checks++;
        if (obs() & {32'h0, {68{1'b1}}}) begin
            errors++; $display("FAIL reset_fields: got %h want 0", obs());
        end
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] words [4];
        words = '{32'h00500093, 32'hFE208CE3, 32'h022081B3, 32'h00000000};
        I_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            I_valid = 1'b1; I_instr = words[i]; I_pc = 32'h100 + 32'(4 * i);
            tick();
            I_valid = 1'b0;
            checks++;
            if (!dut_matches(ref_decode(words[i], I_pc, 1'b1))) begin
                errors++; $display("FAIL directed_model[%0d]: got %h", i, obs());
            end
            checks++;
            case (i)
                0: if ({O_valid, O_class, O_aluop, O_imm, O_rd, O_s2_imm, O_write_reg, O_pc} !==
                       {1'b1, 3'd0, ALUOP_ADD, 32'd5, 5'd1, 1'b1, 1'b1, 32'h100}) begin
                       errors++; $display("FAIL addi: got cls=%0d alu=%0d imm=%h rd=%0d pc=%h want 0/0/5/1/100",
                                          O_class, O_aluop, O_imm, O_rd, O_pc);
                   end
                1: if ({O_valid, O_class, O_imm, O_branchmask, O_write_reg} !==
                       {1'b1, 3'd3, 32'hFFFF_FFF8, 6'b000001, 1'b0}) begin
                       errors++; $display("FAIL beq: got cls=%0d imm=%h bm=%b wr=%b want 3/fffffff8/000001/0",
                                          O_class, O_imm, O_branchmask, O_write_reg);
                   end
                2: begin
                    if ({O_valid, O_aluop, O_write_reg, O_illegal} !== {1'b1, ALUOP_MUL, 1'b1, 1'b0}) begin
                        errors++; $display("FAIL mul_hasmul: got alu=%0d wr=%b ill=%b want %0d/1/0",
                                           O_aluop, O_write_reg, O_illegal, ALUOP_MUL);
                    end
                    checks++;
                    if ({n_valid, n_illegal, n_class, n_write_reg, n_branchmask, n_pc, n_rs1, n_rs2, n_rd, n_funct3} !==
                        {1'b1, 1'b1, 3'd7, 1'b0, 6'd0, 32'h108, 5'd1, 5'd2, 5'd3, 3'd0}) begin
                        errors++; $display("FAIL mul_nomul: got ill=%b cls=%0d wr=%b pc=%h want 1/7/0/108",
                                           n_illegal, n_class, n_write_reg, n_pc);
                    end
                end
                default: if ({O_illegal, O_class, O_write_reg, O_branchmask} !== {1'b1, 3'd7, 1'b0, 6'd0}) begin
                       errors++; $display("FAIL zero_word: got ill=%b cls=%0d wr=%b want 1/7/0",
                                          O_illegal, O_class, O_write_reg);
                   end
            endcase
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4];
        logic [31:0] got_pc [$];
        logic [99:0] snap;
        bit stalled;
        int idx = 0;
        for (int i = 0; i < 4; i++) ins[i] = rand_instr();
        stalled = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            I_valid = (idx < 4);
            I_instr = (idx < 4) ? ins[idx] : 32'h0;
            I_pc    = 32'h200 + 32'(4 * idx);
            I_ready = !(cyc inside {1, 2, 3});
            if (O_valid && I_ready) got_pc.push_back(O_pc);
            if (I_valid && mq.size() < 2) idx++;
            snap = obs();
            stalled = O_valid && !I_ready;
            tick();
            checks++;
            if ({O_valid, O_ready} !== {mq.size() > 0, mq.size() < 2}) begin
                errors++; $display("FAIL b2b_flow cyc%0d: got valid/ready=%b%b want %b%b",
                                   cyc, O_valid, O_ready, mq.size() > 0, mq.size() < 2);
            end
            if (stalled) begin
                checks++;
                if (obs() !== snap) begin
                    errors++; $display("FAIL b2b_stable cyc%0d: got %h want %h", cyc, obs(), snap);
                end
            end
        end
        I_valid = 1'b0;
        checks++;
        if (got_pc.size() != 4) begin
            errors++; $display("FAIL b2b_count: got %0d want 4", got_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_pc[i] !== 32'h200 + 32'(4 * i)) begin
                    errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got_pc[i], 32'h200 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int cyc = 0; cyc < 400; cyc++) begin
            I_valid = ($urandom_range(0, 3) != 0);
            I_instr = rand_instr();
            I_pc    = $urandom & 32'hFFFF_FFFC;
            I_ready = ($urandom_range(0, 9) < 7);
            I_flush = ($urandom_range(0, 39) == 0);
            tick();
            checks++;
            if ({O_valid, O_ready} !== {mq.size() > 0, mq.size() < 2}) begin
                errors++; $display("FAIL rand_flow cyc%0d: got valid/ready=%b%b want %b%b",
                                   cyc, O_valid, O_ready, mq.size() > 0, mq.size() < 2);
            end
            if (mq.size() > 0) begin
                e = ref_decode(mq[0][31:0], mq[0][63:32], 1'b1);
                checks++;
                if (!dut_matches(e)) begin
                    errors++;
                    $display("FAIL rand_payload cyc%0d ins=%h: got pc=%h cls=%0d alu=%0d imm=%h ill=%b wr=%b bm=%b want pc=%h cls=%0d alu=%0d imm=%h ill=%b wr=%b bm=%b",
                             cyc, mq[0][31:0], O_pc, O_class, O_aluop, O_imm, O_illegal, O_write_reg,
                             O_branchmask, e.pc, e.cls, e.aluop, e.imm, e.ill, e.wr, e.bmask);
                end
            end
        end
        I_valid = 1'b0; I_flush = 1'b0; I_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_flush();
        I_ready = 1'b0; I_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            I_instr = rand_instr(); I_pc = 32'h300 + 32'(4 * i);
            tick();
        end
        checks++;
        if ({O_valid, O_ready} !== 2'b10) begin
            errors++; $display("FAIL flush_prefill: got valid/ready=%b%b want 10", O_valid, O_ready);
        end
        I_flush = 1'b1; I_instr = 32'h00500093; I_pc = 32'h308;
        tick();
        I_flush = 1'b0; I_valid = 1'b0;
        checks++;
        if ({O_valid, O_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_clear: got valid/ready=%b%b want 01", O_valid, O_ready);
        end
        I_valid = 1'b1; I_ready = 1'b1; I_instr = 32'h0070_0113; I_pc = 32'h30C;
        tick();
        I_valid = 1'b0;
        checks++;
        if (!(O_valid === 1'b1 && dut_matches(ref_decode(32'h0070_0113, 32'h30C, 1'b1)))) begin
            errors++; $display("FAIL flush_next: got valid=%b pc=%h imm=%h want 1/30c/7", O_valid, O_pc, O_imm);
        end
        tick();
    endtask

    task automatic test_async_reset();
        I_ready = 1'b0; I_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            I_instr = rand_instr(); I_pc = 32'h400 + 32'(4 * i);
            tick();
        end
        I_valid = 1'b0;
        #3;
        I_reset = 1'b1;
        #1;
        mq.delete();
        checks++;
        if ({O_valid, O_ready, O_pc} !== {1'b0, 1'b1, RST_PC}) begin
            errors++; $display("FAIL async_reset: got valid/ready=%b%b pc=%h want 01/%h", O_valid, O_ready, O_pc, RST_PC);
        end
        checks++;
        if (obs() & {32'h0, {68{1'b1}}}) begin
            errors++; $display("FAIL async_reset_fields: got %h want 0", obs());
        end
        #3;
        I_reset = 1'b0;
        tick();
        checks++;
        if ({O_valid, O_ready} !== 2'b01) begin
            errors++; $display("FAIL post_reset: got valid/ready=%b%b want 01", O_valid, O_ready);
        end
        I_ready = 1'b1; I_valid = 1'b1; I_instr = 32'hFE208CE3; I_pc = 32'h500;
        tick();
        I_valid = 1'b0;
        checks++;
        if (!(O_valid === 1'b1 && dut_matches(ref_decode(32'hFE208CE3, 32'h500, 1'b1)))) begin
            errors++; $display("FAIL post_reset_instr: got valid=%b pc=%h cls=%0d want 1/500/3", O_valid, O_pc, O_class);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled instruction decode stage: successor to the purely combinational decoder. Accepts one fetched instruction plus PC per cycle over a valid/ready handshake, decodes RV32I (plus RV32M when `HAS_MUL=1`) with full illegal-encoding detection, and presents results from an output register backed by a one-entry skid buffer. It sits between fetch and execute and allows the core to move from a multi-cycle FSM to a pipelined datapath.

## Interface

Parameters:
- `HAS_MUL`, 1: accept funct7=0000001 on OP as M-extension; when 0, such encodings are illegal.
- `RESET_PC`, 32'h0: value driven on `O_pc` while `O_valid`=0 after reset.

Ports:
- `I_clk`  in  1  clock, all state on rising edge.
- `I_reset`  in  1  asynchronous, active-high reset.
- `I_flush`  in  1  synchronous: drop all buffered instructions.
- `I_valid`  in  1  upstream instruction valid.
- `O_ready`  out  1  stage can accept; registered, equals "skid entry empty".
- `I_instr`  in  32  instruction word.
- `I_pc`  in  32  instruction address.
- `O_valid`  out  1  decoded instruction valid.
- `I_ready`  in  1  downstream accepts this cycle.
- `O_pc`  out  32  PC of decoded instruction.
- `O_rs1`, `O_rs2`, `O_rd`  out  5 each  instr[19:15], [24:20], [11:7].
- `O_imm`  out  32  sign-extended immediate (I/S/B/U/J per opcode).
- `O_funct3`  out  3  instr[14:12].
- `O_aluop`  out  5  existing `ALUOP_*` code.
- `O_s1_pc`  out  1  ALU operand 1 is PC (AUIPC, JAL).
- `O_s2_imm`  out  1  ALU operand 2 is immediate.
- `O_class`  out  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 LUI, 6 SYSTEM/MISCMEM, 7 TRAP.
- `O_branchmask`  out  6  one-hot BEQ,BNE,BLT,BGE,BLTU,BGEU (bit 0..5); 0 unless class BRANCH.
- `O_write_reg`  out  1  instruction writes rd and rd≠0.
- `O_illegal`  out  1  illegal encoding; forces class TRAP, write_reg 0, branchmask 0.

## Operation

- Decode is combinational from the incoming word; results are captured into the output register (main) or skid register, never re-decoded.
- Illegal when: instr[1:0]≠11; opcode not in {LOAD, STORE, BRANCH, JAL, JALR, OP, OPIMM, LUI, AUIPC, MISCMEM, SYSTEM}; BRANCH funct3 ∈ {010,011}; JALR funct3≠000; LOAD funct3 ∈ {011,110,111}; STORE funct3 ≥ 011; OP funct7 ∉ {0000000, 0100000, 0000001}, or 0100000 with funct3 ∉ {000,101}, or 0000001 with `HAS_MUL`=0; OPIMM shifts (001,101) with funct7 ∉ {0000000, 0100000 (101 only)}.
- ALU op mapping: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; M ops MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU by funct3; LOAD/STORE/JAL/JALR/AUIPC/BRANCH use ADD.
- `O_write_reg`: class ALU, LOAD, JUMP, LUI, and rd≠0; 0 for rd=x0.
- State: main entry (valid + payload), skid entry (valid + payload).
  - Accept = `I_valid & O_ready`. Drain = `O_valid & I_ready`.
  - Main empty or draining: accepted instruction (or skid contents if skid valid) loads main; skid content has priority and skid clears.
  - Main full and not draining: accepted instruction loads skid.
  - `O_ready` registered: next value = !(skid valid next).
- Ordering preserved strictly FIFO.

## Timing

- Reset (async): `O_valid`=0, skid empty, `O_ready`=1, `O_pc`=`RESET_PC`, all other outputs 0 (`O_class`=0, `O_illegal`=0).
- Latency 1: instruction accepted in cycle N appears on outputs in cycle N+1.
- Throughput 1/cycle with `I_ready` held high; `O_ready` never deasserts then.
- Backpressure: `I_ready` low with main full → one further accept lands in skid, `O_ready` drops next cycle; at most 2 instructions buffered.
- Payload on outputs holds stable while `O_valid`=1 and `I_ready`=0.
- `I_flush`: next cycle `O_valid`=0, skid empty, `O_ready`=1; an `I_valid` in the flush cycle is discarded. Flush wins over simultaneous accept/drain.
- Reset mid-transfer: buffered instructions lost, no output glitch beyond async clear.

## Test plan

- Drive 0x00500093 (addi x1,x0,5), `I_pc`=0x100 -> next cycle O_valid=1, class 0, aluop ADD, imm=5, rd=1, s2_imm=1, write_reg=1, pc=0x100.
- Drive 0xFE208CE3 (beq x1,x2,-8) -> class 3, imm=0xFFFFFFF8, branchmask=6'b000001, write_reg=0.
- Drive 0x022081B3 (mul x3,x1,x2): `HAS_MUL`=1 -> aluop MUL, write_reg=1; `HAS_MUL`=0 -> illegal=1, class 7, write_reg=0. Also 0x00000000 -> illegal.
- Stream A,B,C,D back-to-back, `I_ready` low 3 cycles from A's arrival -> B enters skid, O_ready low, C held upstream; output order A,B,C,D, no loss/duplication, payload stable while stalled.
- With main and skid full, assert `I_flush` together with `I_valid` -> next cycle O_valid=0, O_ready=1; next instruction emerges with 1-cycle latency.
- Assert `I_reset` asynchronously between edges with two buffered -> outputs clear immediately to reset values; O_ready=1 after release.
